ps2_key_events: RTL

Parametrised PS/2 keyboard front end that turns raw PS/2 frames into decoded key events, with make/break/extended classification, typematic-repeat detection, a press counter and a buffered event queue. It sits between the PS/2 pins and the display/ASCII-lookup logic. The consumer pops whole key events instead of raw scancode bytes.

---
 rtl/ps2_key_events.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_events.sv
// PS/2 keyboard front end: synchronises the raw PS/2 pins, assembles and checks
// 11-bit frames, decodes prefix bytes into make/break/extended key events,
// tracks the held key for typematic-repeat detection and buffers events in a
// first-word-fall-through queue.
//
// Decoder states
//   state      | meaning
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen, waiting for code or F0
//   ST_BRK     | F0 seen, next byte is a release code
//   ST_EXT_BRK | E0 F0 seen, next byte is an extended release code
module ps2_key_events #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_first,
  output logic [CNT_W-1:0] press_count,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic             overflow,
  output logic             parity_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ENT_W = 11;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, sdat_q, sdat_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   byte_stb_q, byte_stb_d;
  logic [7:0]             byte_q, byte_d;
  logic                   perr_q, perr_d;
  state_t                 state_q, state_d;
  logic                   key_held_q, key_held_d;
  logic [7:0]             held_code_q, held_code_d;
  logic                   held_ext_q, held_ext_d;
  logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic       fall, data_bit;
  logic       emit, ev_ext_n, ev_brk_n, ev_first_n, match;
  logic       pop, full, push_ok;
  logic [ENT_W-1:0] head;

  assign fall     = sclk_prev_q & ~sclk_q[SYNC_STAGES-1];
  assign data_bit = sdat_q[SYNC_STAGES-1];

  // Shift the raw pins through the synchroniser chains.
  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], ps2_clk};
    sdat_d      = {sdat_q[SYNC_STAGES-2:0], ps2_data};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
  end

  // Frame assembly, frame check and partial-frame timeout.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmr_d      = tmr_q;
    byte_stb_d = 1'b0;
    byte_d     = byte_q;
    perr_d     = 1'b0;
    if (fall) begin
      tmr_d = TMR_W'(TIMEOUT_CYC - 1);
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q[0]=start, [8:1]=data, [9]=parity; data_bit is the stop bit
        if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
          byte_stb_d = 1'b1;
          byte_d     = shift_q[8:1];
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_bit, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmr_q == '0) bit_cnt_d = 4'd0;
      else             tmr_d     = tmr_q - TMR_W'(1);
    end
  end

  // Prefix decoder; a rejected frame abandons any pending prefix.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    ev_ext_n = 1'b0;
    ev_brk_n = 1'b0;
    if (perr_q) begin
      state_d = ST_IDLE;
    end else if (byte_stb_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == 8'hE0)      state_d = ST_EXT;
          else if (byte_q == 8'hF0) state_d = ST_BRK;
          else                      emit    = 1'b1;
        end
        ST_EXT: begin
          if (byte_q == 8'hF0)      state_d = ST_EXT_BRK;
          else if (byte_q == 8'hE0) state_d = ST_EXT;
          else begin
            emit     = 1'b1;
            ev_ext_n = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (byte_q != 8'hE0 && byte_q != 8'hF0) begin
            emit     = 1'b1;
            ev_brk_n = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (byte_q != 8'hE0 && byte_q != 8'hF0) begin
            emit     = 1'b1;
            ev_ext_n = 1'b1;
            ev_brk_n = 1'b1;
          end
        end
      endcase
    end
  end

  // Held-key tracking and fresh-press counting.
  always_comb begin
    match       = key_held_q && (byte_q == held_code_q) && (ev_ext_n == held_ext_q);
    ev_first_n  = emit && !ev_brk_n && !match;
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    press_cnt_d = press_cnt_q;
    if (emit) begin
      if (!ev_brk_n) begin
        if (!match) begin
          press_cnt_d = press_cnt_q + CNT_W'(1);
          key_held_d  = 1'b1;
          held_code_d = byte_q;
          held_ext_d  = ev_ext_n;
        end
      end else if (match) begin
        key_held_d = 1'b0;
      end
    end
  end

  // Event queue; a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    push_ok  = emit && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {ev_ext_n, ev_brk_n, ev_first_n, byte_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      ovf_d    = 1'b0;
    end
    if (emit && !push_ok) ovf_d = 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; synchronisers reset to the idle-high bus level.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sclk_q      <= '1;
      sdat_q      <= '1;
      sclk_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmr_q       <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      state_q     <= ST_IDLE;
      key_held_q  <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      press_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmr_q       <= tmr_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      state_q     <= state_d;
      key_held_q  <= key_held_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      press_cnt_q <= press_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign ev_valid    = (count_q != '0);
  assign ev_code     = ev_valid ? head[7:0] : 8'h00;
  assign ev_first    = ev_valid & head[8];
  assign ev_break    = ev_valid & head[9];
  assign ev_ext      = ev_valid & head[10];
  assign press_count = press_cnt_q;
  assign key_held    = key_held_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign overflow    = ovf_q;
  assign parity_err  = perr_q;

endmodule
